// File: rtl/thread_sched.sv
// Round-robin fetch-thread selector with per-thread eligibility FSMs.
// Tracks misses, fills, hazard backoff and flushes; drives history invalidates.
module thread_sched #(
  parameter int NTHREADS   = 4,
  parameter int TIDW       = $clog2(NTHREADS),
  parameter int REPLAY_DLY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NTHREADS-1:0] thread_en,
  input  logic                fetch_stall,
  input  logic                miss_valid,
  input  logic [TIDW-1:0]     miss_thread,
  input  logic                fill_valid,
  input  logic [TIDW-1:0]     fill_thread,
  input  logic                hz_block,
  input  logic [TIDW-1:0]     hz_thread,
  input  logic                flush_en,
  input  logic [TIDW-1:0]     flush_thread,
  output logic                fetch_valid,
  output logic [TIDW-1:0]     fetch_thread,
  output logic                invalidate_en,
  output logic [TIDW-1:0]     invalidate_thread,
  output logic [NTHREADS-1:0] miss_pending
);
  localparam int CW = $clog2(REPLAY_DLY + 2);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READY = 2'd1;
  localparam logic [1:0] S_MISS  = 2'd2;
  localparam logic [1:0] S_BACK  = 2'd3;

  typedef logic [TIDW-1:0] threadid_t;

  logic [1:0]          state  [NTHREADS];
  logic [1:0]          nstate [NTHREADS];
  logic [CW-1:0]       cnt    [NTHREADS];
  logic [CW-1:0]       ncnt   [NTHREADS];
  logic [NTHREADS-1:0] dis;
  logic [NTHREADS-1:0] pend;
  logic [NTHREADS-1:0] dmask;
  logic [NTHREADS-1:0] elig;
  logic [NTHREADS-1:0] mp;
  threadid_t           rr_ptr;
  threadid_t           grant;
  threadid_t           idx;
  threadid_t           low;
  threadid_t           inv_tq;
  logic                inv_q;
  logic                found;

  always_comb begin
    for (int t = 0; t < NTHREADS; t++) begin
      nstate[t] = state[t];
      ncnt[t]   = cnt[t];
      dis[t]    = 1'b0;
      // a missing thread must see its fill before it can go idle
      if (state[t] == S_MISS) begin
        if (fill_valid && fill_thread == threadid_t'(t))
          nstate[t] = thread_en[t] ? S_READY : S_IDLE;
      end else if (!thread_en[t]) begin
        nstate[t] = S_IDLE;
        ncnt[t]   = '0;
        dis[t]    = (state[t] != S_IDLE);
      end else if (state[t] == S_IDLE) begin
        nstate[t] = S_READY;
      end else if (flush_en && flush_thread == threadid_t'(t)) begin
        nstate[t] = S_READY;
        ncnt[t]   = '0;
      end else if (state[t] == S_READY) begin
        if (miss_valid && miss_thread == threadid_t'(t)) begin
          nstate[t] = S_MISS;
        end else if (hz_block && hz_thread == threadid_t'(t)
                     && REPLAY_DLY != 0) begin
          nstate[t] = S_BACK;
          ncnt[t]   = CW'(REPLAY_DLY);
        end
      end else begin
        if (cnt[t] == CW'(1)) begin
          nstate[t] = S_READY;
          ncnt[t]   = '0;
        end else begin
          ncnt[t] = cnt[t] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int t = 0; t < NTHREADS; t++) begin
      elig[t] = (state[t] == S_READY);
      mp[t]   = (state[t] == S_MISS);
    end
  end

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NTHREADS; i++) begin
      idx = rr_ptr + threadid_t'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign dmask = dis | pend;

  always_comb begin
    low = '0;
    for (int t = NTHREADS - 1; t >= 0; t--)
      if (dmask[t]) low = threadid_t'(t);
  end

  assign fetch_valid       = found && !fetch_stall && !rst;
  assign fetch_thread      = fetch_valid ? grant : '0;
  assign invalidate_en     = inv_q && !rst;
  assign invalidate_thread = rst ? '0 : inv_tq;
  assign miss_pending      = rst ? '0 : mp;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NTHREADS; t++) begin
        state[t] <= S_IDLE;
        cnt[t]   <= '0;
      end
      rr_ptr <= threadid_t'(NTHREADS - 1);
      inv_q  <= 1'b0;
      inv_tq <= '0;
      pend   <= '0;
    end else begin
      for (int t = 0; t < NTHREADS; t++) begin
        state[t] <= nstate[t];
        cnt[t]   <= ncnt[t];
      end
      if (fetch_valid) rr_ptr <= fetch_thread;
      // flush owns the port; disable pulses queue behind it
      if (flush_en) begin
        inv_q  <= 1'b1;
        inv_tq <= flush_thread;
        pend   <= dmask;
      end else if (|dmask) begin
        inv_q  <= 1'b1;
        inv_tq <= low;
        pend   <= dmask & ~({{(NTHREADS-1){1'b0}}, 1'b1} << low);
      end else begin
        inv_q  <= 1'b0;
        inv_tq <= '0;
        pend   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_thread_sched.sv
// Scoreboard bench for thread_sched: reference model plus directed
// rotation, miss, backoff, flush, stall, disable and reset scenarios.
module tb_thread_sched;
  localparam int IDLE = 0, READY = 1, MISS = 2, BACK = 3;
  localparam int DLY = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] thread_en;
  logic       fetch_stall;
  logic       miss_valid;
  logic [1:0] miss_thread;
  logic       fill_valid;
  logic [1:0] fill_thread;
  logic       hz_block;
  logic [1:0] hz_thread;
  logic       flush_en;
  logic [1:0] flush_thread;
  logic       fetch_valid;
  logic [1:0] fetch_thread;
  logic       invalidate_en;
  logic [1:0] invalidate_thread;
  logic [3:0] miss_pending;

  thread_sched #(.NTHREADS(4), .REPLAY_DLY(DLY)) dut (
    .clk(clk), .rst(rst), .thread_en(thread_en),
    .fetch_stall(fetch_stall),
    .miss_valid(miss_valid), .miss_thread(miss_thread),
    .fill_valid(fill_valid), .fill_thread(fill_thread),
    .hz_block(hz_block), .hz_thread(hz_thread),
    .flush_en(flush_en), .flush_thread(flush_thread),
    .fetch_valid(fetch_valid), .fetch_thread(fetch_thread),
    .invalidate_en(invalidate_en),
    .invalidate_thread(invalidate_thread),
    .miss_pending(miss_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v; int th; int ie; int it; int mp;
  } exp_t;

  exp_t sb[$];
  int npass = 0;
  int ntot  = 0;
  int m_st[4];
  int m_cnt[4];
  int m_rr = 3;
  int m_pend = 0;
  int m_ie = 0;
  int m_it = 0;
  int o_v, o_th, o_ie, o_it, o_mp;

  task automatic check(input string tag, input int obs, input int exp);
    ntot++;
    if (obs == exp) npass++;
    else $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
  endtask

  task automatic mgrant(output int g, output bit f);
    int t;
    f = 0;
    g = 0;
    for (int k = 1; k <= 4; k++) begin
      t = (m_rr + k) % 4;
      if (!f && m_st[t] == READY) begin
        f = 1;
        g = t;
      end
    end
  endtask

  task automatic model_out(output exp_t e);
    int g;
    bit f;
    e = '{0, 0, 0, 0, 0};
    if (!rst) begin
      mgrant(g, f);
      e.v  = (f && !fetch_stall) ? 1 : 0;
      e.th = e.v ? g : 0;
      e.ie = m_ie;
      e.it = m_it;
      for (int t = 0; t < 4; t++)
        if (m_st[t] == MISS) e.mp |= (1 << t);
    end
  endtask

  task automatic model_update();
    int g, dis, dm, low;
    bit f, en, fl;
    int ns[4];
    int nc[4];
    if (rst) begin
      for (int t = 0; t < 4; t++) begin
        m_st[t]  = IDLE;
        m_cnt[t] = 0;
      end
      m_rr = 3; m_pend = 0; m_ie = 0; m_it = 0;
      return;
    end
    mgrant(g, f);
    if (f && !fetch_stall) m_rr = g;
    dis = 0;
    for (int t = 0; t < 4; t++) begin
      en = thread_en[t];
      fl = flush_en && flush_thread == t;
      ns[t] = m_st[t];
      nc[t] = m_cnt[t];
      case (m_st[t])
        MISS:
          if (fill_valid && fill_thread == t) ns[t] = en ? READY : IDLE;
        IDLE:
          if (en) ns[t] = READY;
        READY:
          if (!en) begin
            ns[t] = IDLE; dis |= (1 << t);
          end else if (fl) begin
            ns[t] = READY;
          end else if (miss_valid && miss_thread == t) begin
            ns[t] = MISS;
          end else if (hz_block && hz_thread == t && DLY > 0) begin
            ns[t] = BACK; nc[t] = DLY;
          end
        default:
          if (!en) begin
            ns[t] = IDLE; nc[t] = 0; dis |= (1 << t);
          end else if (fl || m_cnt[t] == 1) begin
            ns[t] = READY; nc[t] = 0;
          end else begin
            nc[t] = m_cnt[t] - 1;
          end
      endcase
    end
    for (int t = 0; t < 4; t++) begin
      m_st[t]  = ns[t];
      m_cnt[t] = nc[t];
    end
    dm = dis | m_pend;
    if (flush_en) begin
      m_ie = 1; m_it = flush_thread; m_pend = dm;
    end else if (dm != 0) begin
      low = 0;
      while (!dm[low]) low++;
      m_ie = 1; m_it = low; m_pend = dm & ~(1 << low);
    end else begin
      m_ie = 0; m_it = 0; m_pend = 0;
    end
  endtask

  // one cycle: push model expectation, compare DUT mid-cycle, advance
  task automatic cyc();
    exp_t e, g;
    model_out(e);
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    o_v = fetch_valid; o_th = fetch_thread;
    o_ie = invalidate_en; o_it = invalidate_thread;
    o_mp = miss_pending;
    check("sb_valid", o_v, g.v);
    check("sb_thread", o_th, g.th);
    check("sb_inv_en", o_ie, g.ie);
    check("sb_inv_th", o_it, g.it);
    check("sb_miss_pend", o_mp, g.mp);
    @(posedge clk);
    model_update();
    #1;
    miss_valid = 0; fill_valid = 0; hz_block = 0; flush_en = 0;
  endtask

  task automatic grant_is(input string tag, input int th);
    cyc();
    check(tag, o_v, 1);
    check(tag, o_th, th);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1; thread_en = 0; fetch_stall = 0;
    miss_valid = 0; miss_thread = 0; fill_valid = 0; fill_thread = 0;
    hz_block = 0; hz_thread = 0; flush_en = 0; flush_thread = 0;
    @(posedge clk); #1;
    cyc();
    cyc();
    check("rst_valid", o_v, 0);
    check("rst_mp", o_mp, 0);
    check("rst_inv", o_ie, 0);

    rst = 0; thread_en = 4'b1111;
    cyc();
    check("t1_first", o_v, 0);
    for (int i = 0; i < 5; i++) grant_is("t1_grant", i % 4);

    miss_valid = 1; miss_thread = 1;
    grant_is("t2_hit", 1);
    for (int i = 0; i < 6; i++) begin
      grant_is("t2_rot", (i % 3 == 0) ? 2 : (i % 3 == 1) ? 3 : 0);
      check("t2_mp", o_mp, 4'b0010);
    end
    fill_valid = 1; fill_thread = 1;
    grant_is("t2_fill", 2);
    grant_is("t2_back", 3);
    grant_is("t2_back", 0);
    grant_is("t2_back", 1);
    check("t2_mp_clr", o_mp, 0);

    grant_is("t3a_pre", 2);
    grant_is("t3a_pre", 3);
    grant_is("t3a_pre", 0);
    hz_block = 1; hz_thread = 2;
    grant_is("t3a_hz", 1);
    fetch_stall = 1;
    cyc();
    cyc();
    check("t3a_stall", o_v, 0);
    fetch_stall = 0;
    grant_is("t3a_rejoin", 2);
    grant_is("t3b_pre", 3);
    grant_is("t3b_pre", 0);
    hz_block = 1; hz_thread = 2;
    grant_is("t3b_hz", 1);
    fetch_stall = 1;
    cyc();
    fetch_stall = 0;
    grant_is("t3b_absent", 3);
    grant_is("t3b_next", 0);

    hz_block = 1; hz_thread = 3;
    grant_is("t4_hz", 1);
    flush_en = 1; flush_thread = 3;
    grant_is("t4_flush", 2);
    check("t4_inv_en0", o_ie, 0);
    grant_is("t4_ready", 3);
    check("t4_inv_en", o_ie, 1);
    check("t4_inv_th", o_it, 3);
    grant_is("t4_after", 0);
    check("t4_inv_off", o_ie, 0);

    grant_is("t5_rr1", 1);
    fetch_stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t5_stall_v", o_v, 0);
      check("t5_stall_th", o_th, 0);
    end
    fetch_stall = 0;
    grant_is("t5_resume", 2);
    miss_valid = 1; miss_thread = 0;
    grant_is("t5_miss", 3);
    fill_valid = 1; fill_thread = 0;
    miss_valid = 1; miss_thread = 0;
    grant_is("t5_fm", 1);
    check("t5_fm_mp", o_mp, 4'b0001);
    grant_is("t5_fm2", 2);
    check("t5_fm_mp2", o_mp, 0);
    grant_is("t5_fm3", 3);
    grant_is("t5_ready0", 0);

    thread_en = 4'b1011; flush_en = 1; flush_thread = 0;
    grant_is("dis_cyc", 1);
    grant_is("dis_skip", 3);
    check("dis_fl_en", o_ie, 1);
    check("dis_fl_th", o_it, 0);
    grant_is("dis_next", 0);
    check("dis_pulse_en", o_ie, 1);
    check("dis_pulse_th", o_it, 2);
    thread_en = 4'b1111;
    grant_is("dis_reen", 1);
    check("dis_pulse_off", o_ie, 0);

    miss_valid = 1; miss_thread = 0;
    cyc();
    miss_valid = 1; miss_thread = 1;
    cyc();
    cyc();
    check("t6_mp", o_mp, 4'b0011);
    rst = 1;
    cyc();
    check("t6_rst_v", o_v, 0);
    check("t6_rst_mp", o_mp, 0);
    rst = 0; thread_en = 0; fill_valid = 1; fill_thread = 0;
    cyc();
    cyc();
    check("t6_stale_v", o_v, 0);
    check("t6_stale_mp", o_mp, 0);
    thread_en = 4'b1111;
    cyc();
    grant_is("t6_restart", 0);
    grant_is("t6_restart", 1);

    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) thread_en = 4'($urandom) | 4'($urandom);
      rst          = (i == 200);
      fetch_stall  = ($urandom_range(0, 7) == 0);
      miss_valid   = ($urandom_range(0, 3) == 0);
      miss_thread  = 2'($urandom);
      fill_valid   = ($urandom_range(0, 2) == 0);
      fill_thread  = 2'($urandom);
      hz_block     = ($urandom_range(0, 3) == 0);
      hz_thread    = 2'($urandom);
      flush_en     = ($urandom_range(0, 5) == 0);
      flush_thread = 2'($urandom);
      cyc();
    end
    rst = 0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
